// File: rtl/pool_window_accumulator_pkg.sv
// Shared Q6.10 fixed-point definitions for the average-pooling path.
// Used by the 2x2 window summer and the downstream divide stage.
package pool_window_accumulator_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 10;

    localparam logic [DATA_W-1:0] ONE     = 16'h0400;
    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    localparam logic [0:0] EVEN_ROW = 1'b0;
    localparam logic [0:0] ODD_ROW  = 1'b1;

    // Sum of four Q6.10 values needs two guard bits; clamp back to 16.
    function automatic logic [DATA_W-1:0] saturate(
        input logic [DATA_W+1:0] sum
    );
        logic [2:0] top;
        top = sum[DATA_W+1:DATA_W-1];
        if (top == 3'b000 || top == 3'b111) begin
            return sum[DATA_W-1:0];
        end else if (sum[DATA_W+1]) begin
            return SAT_MIN;
        end else begin
            return SAT_MAX;
        end
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row storage of horizontal pair sums for the 2x2 pooling window.
// One synchronous write port, one asynchronous read port, no reset.
module pool_line_buffer #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 17,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_accumulator.sv
// Streaming 2x2 window summer feeding the LeNet5 average-pool divide stage.
// Pixels arrive row-major; one saturated window sum per 2x2 block.
module pool_window_accumulator
    import pool_window_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair;

    logic                  xfer;
    logic [0:0]            phase;
    logic                  lb_we;
    logic                  win_done;
    logic                  win_last;
    logic [AW-1:0]         lb_addr;
    logic [DATA_WIDTH:0]   lb_rdata;
    logic [DATA_WIDTH:0]   pair_sum;
    logic [DATA_WIDTH+1:0] win_sum;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign phase    = row[0];
    assign lb_addr  = AW'(col >> 1);
    assign win_last = (row == ROW_LAST) && (col == COL_LAST);

    assign pair_sum = {pair[DATA_WIDTH-1], pair}
                    + {in_data[DATA_WIDTH-1], in_data};

    assign win_sum = {lb_rdata[DATA_WIDTH], lb_rdata}
                   + {{2{pair[DATA_WIDTH-1]}}, pair}
                   + {{2{in_data[DATA_WIDTH-1]}}, in_data};

    // Odd column closes a pair: even rows park it, odd rows finish the window.
    always_comb begin
        lb_we    = 1'b0;
        win_done = 1'b0;
        unique case (phase)
            EVEN_ROW: lb_we    = xfer && col[0];
            ODD_ROW:  win_done = xfer && col[0];
        endcase
    end

    pool_line_buffer #(
        .DEPTH (LB_DEPTH),
        .WIDTH (DATA_WIDTH + 1),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_sum),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            col       <= '0;
            row       <= '0;
            pair      <= '0;
        end else begin
            if (win_done) begin
                out_valid <= 1'b1;
                out_data  <= saturate(win_sum);
                out_last  <= win_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (xfer) begin
                if (!col[0]) begin
                    pair <= in_data;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_window_accumulator.sv
// Directed bench: small 4x2 instance for window/corner cases,
// default 28x28 instance for back-to-back frame streaming.
module tb_pool_window_accumulator;
    import pool_window_accumulator_pkg::*;

    logic clk;
    logic rst_n;

    logic [15:0] s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_out_last;

    logic [15:0] l_in_data;
    logic        l_in_valid;
    logic        l_in_ready;
    logic [15:0] l_out_data;
    logic        l_out_valid;
    logic        l_out_ready;
    logic        l_out_last;

    int n_chk;
    int n_fail;
    int s_out_cnt;

    logic [15:0] exp_l [392];

    pool_window_accumulator #(
        .DATA_WIDTH (16),
        .IMG_W      (4),
        .IMG_H      (2)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_last  (s_out_last)
    );

    pool_window_accumulator dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (l_in_data),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .out_data  (l_out_data),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .out_last  (l_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            s_out_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] p);
        int n;
        n = 0;
        s_in_data  = p;
        s_in_valid = 1'b1;
        while (!s_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            chk("push_timeout", 32'(n), 32'd0);
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    // w[3],w[2] = top-row pair, w[1],w[0] = bottom-row pair of a window.
    task automatic frame42(input string tag,
                           input logic [3:0][15:0] w0,
                           input logic [3:0][15:0] w1,
                           input logic [15:0] e0,
                           input logic [15:0] e1);
        push(w0[3]);
        push(w0[2]);
        push(w1[3]);
        push(w1[2]);
        push(w0[1]);
        chk({tag, "_pre_valid"}, 32'(s_out_valid), 32'd0);
        push(w0[0]);
        chk({tag, "_w0_valid"}, 32'(s_out_valid), 32'd1);
        chk({tag, "_w0_data"}, 32'(s_out_data), 32'(e0));
        chk({tag, "_w0_last"}, 32'(s_out_last), 32'd0);
        push(w1[1]);
        chk({tag, "_mid_valid"}, 32'(s_out_valid), 32'd0);
        push(w1[0]);
        chk({tag, "_w1_valid"}, 32'(s_out_valid), 32'd1);
        chk({tag, "_w1_data"}, 32'(s_out_data), 32'(e1));
        chk({tag, "_w1_last"}, 32'(s_out_last), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ramp(input int f, input int i);
        logic [31:0] u;
        u = 32'(i * 97 + f * 5003);
        return u[15:0];
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] sat16(input int s);
        logic [31:0] u;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        u = 32'(s);
        return u[15:0];
    endfunction

    initial begin
        int s;
        int k;
        int lastcnt;
        int cnt_snap;
        n_chk       = 0;
        n_fail      = 0;
        s_out_cnt   = 0;
        rst_n       = 1'b0;
        s_in_data   = '0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        l_in_data   = '0;
        l_in_valid  = 1'b0;
        l_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_out_data", 32'(s_out_data), 32'd0);
        chk("rst_out_last", 32'(s_out_last), 32'd0);
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("rst_l_out_valid", 32'(l_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        frame42("ones", {ONE, ONE, ONE, ONE}, {ONE, ONE, ONE, ONE},
                16'h1000, 16'h1000);
        frame42("signs",
                {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00},
                {16'h0400, 16'hFC00, 16'h0800, 16'h0000},
                16'hF000, 16'h0800);
        frame42("sat_ext",
                {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                {16'h8000, 16'h8000, 16'h8000, 16'h8000},
                16'h7FFF, 16'h8000);
        frame42("sat_pos",
                {16'h7000, 16'h7000, 16'h0000, 16'h0000},
                {16'h0001, 16'h0002, 16'h0003, 16'h0004},
                16'h7FFF, 16'h000A);
        chk("count_after_basic", 32'(s_out_cnt), 32'd8);

        // Backpressure with first window pending.
        s_out_ready = 1'b0;
        push(16'h0200);
        push(16'h0200);
        push(16'h0010);
        push(16'h0020);
        push(16'h0200);
        push(16'h0200);
        chk("bp_valid", 32'(s_out_valid), 32'd1);
        chk("bp_data", 32'(s_out_data), 32'h0800);
        s_in_data  = 16'h0030;
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(s_in_ready), 32'd0);
            chk("bp_hold_data", 32'(s_out_data), 32'h0800);
            chk("bp_hold_valid", 32'(s_out_valid), 32'd1);
        end
        chk("bp_count_frozen", 32'(s_out_cnt), 32'd8);
        s_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        chk("bp_drained", 32'(s_out_valid), 32'd0);
        push(16'h0040);
        chk("bp_w1_valid", 32'(s_out_valid), 32'd1);
        chk("bp_w1_data", 32'(s_out_data), 32'h00A0);
        chk("bp_w1_last", 32'(s_out_last), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_count", 32'(s_out_cnt), 32'd10);

        // Reset after three pixels of the odd row.
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        push(16'h0555);
        push(16'h0666);
        push(16'h0777);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(s_out_valid), 32'd0);
        chk("mid_rst_last", 32'(s_out_last), 32'd0);
        chk("mid_rst_data", 32'(s_out_data), 32'd0);
        rst_n = 1'b1;
        cnt_snap = s_out_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_out", 32'(s_out_cnt), 32'(cnt_snap));
        chk("mid_rst_valid2", 32'(s_out_valid), 32'd0);
        frame42("post_rst",
                {16'h0100, 16'h0200, 16'h0300, 16'h0400},
                {16'hFF00, 16'hFF00, 16'h0100, 16'h0000},
                16'h0A00, 16'hFF00);
        chk("final_small_count", 32'(s_out_cnt), 32'd13);

        // Two back-to-back 28x28 ramp frames.
        for (int f = 0; f < 2; f++) begin
            for (int wr = 0; wr < 14; wr++) begin
                for (int wc = 0; wc < 14; wc++) begin
                    s = 0;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            s += sx(ramp(f, (2*wr+dr)*28 + 2*wc + dc));
                        end
                    end
                    exp_l[f*196 + wr*14 + wc] = sat16(s);
                end
            end
        end
        k = 0;
        lastcnt = 0;
        for (int i = 0; i < 1568; i++) begin
            l_in_data  = ramp(i / 784, i % 784);
            l_in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (l_out_valid) begin
                if (k < 392) begin
                    chk($sformatf("big_data_%0d", k),
                        32'(l_out_data), 32'(exp_l[k]));
                    chk($sformatf("big_last_%0d", k), 32'(l_out_last),
                        (k == 195 || k == 391) ? 32'd1 : 32'd0);
                end
                if (l_out_last) lastcnt++;
                k++;
            end
        end
        l_in_valid = 1'b0;
        chk("big_in_ready", 32'(l_in_ready), 32'd1);
        chk("big_count", 32'(k), 32'd392);
        chk("big_last_count", 32'(lastcnt), 32'd2);
        @(posedge clk);
        #1;
        chk("big_idle", 32'(l_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_accumulator.md
Name: pool_window_accumulator

Overview:
- Streaming 2x2 window summer for the LeNet5 average-pooling path (S2/S4 layers).
- Consumes one convolution-output pixel per handshake in row-major order (fixed-point Q6.10).
- Emits one 2x2 window sum per window. The downstream ×0.25 divide stage turns the sum into the average.
- This block is the producer end of the divide stage's input; it completes the pooling interface.

Parameters:
- DATA_WIDTH, 16, pixel and sum width (signed two's complement Q6.10).
- IMG_W, 28, input row length in pixels; must be even and ≥2.
- IMG_H, 28, input rows per frame; must be even and ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_WIDTH  input pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- out_data  out  DATA_WIDTH  saturated 2x2 window sum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final window of a frame; qualified by out_valid.

Behaviour:
- Clock and reset:
  - One clock, clk. rst_n is synchronous and active-low.
  - While rst_n=0 on a rising edge: out_valid=0, out_data=0, out_last=0, col=0, row=0, pair register cleared.
  - in_ready is combinational and reads 1 as soon as out_valid=0.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (single output register, full throughput, no bubble).
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1; both advance only on input transfer.
  - col wraps to 0 and increments row. row wraps to 0 after IMG_H-1, so the next frame starts seamlessly.
- Phase FSM, derived from row[0]:
  - EVEN_ROW (row even):
    - col even: store pixel in pair register.
    - col odd: line_buf[col>>1] ← sign-extended pair + pixel (DATA_WIDTH+1 bits).
  - ODD_ROW (row odd):
    - col even: store pixel in pair register.
    - col odd: sum = line_buf[col>>1] + pair + pixel, computed in DATA_WIDTH+2 bits.
    - On that same edge, out_data ← saturate(sum), out_valid ← 1, and out_last ← (row==IMG_H-1 && col==IMG_W-1).
- line_buf:
  - IMG_W/2 entries of DATA_WIDTH+1 bits, register array, no reset required.
  - Every entry is written in an even row before it is read in the following odd row.
- Arithmetic:
  - Full-precision signed add, then saturate to DATA_WIDTH: >2^(DW-1)-1 → 0x7FFF; <-2^(DW-1) → 0x8000 (DW=16).
  - No rounding; frac bits pass through unchanged.
- Latency and rate:
  - Output is registered on the edge that accepts the 4th pixel of a window, so out_valid rises 1 cycle after that transfer.
  - Per frame: (IMG_W/2)*(IMG_H/2) outputs.
- Simultaneous events:
  - Output transfer and a new window completion on the same edge: the register reloads and out_valid stays 1.
  - Output transfer with no new window: out_valid ← 0.
- Backpressure: while in_ready=0, counters, pair register and line_buf are frozen.
- Reset mid-frame: partial window discarded, counters to (0,0), no spurious output. The next input is treated as pixel (0,0).

Decomposition:
- Shared package: Q6.10 constants (FRAC_BITS=10, ONE=16'h0400) and saturation bounds.
- Helper function saturate(sum) also goes in the shared package; the divide stage reuses both.
- One natural sub-module, pool_line_buffer (IMG_W/2 × DATA_WIDTH+1, one write port, one async read port). Counters, FSM and adder stay in the top module.

Test Plan:
- IMG_W=4, IMG_H=2, out_ready=1. All 8 pixels = 0x0400 (1.0) → two outputs of 0x1000 (4.0), second with out_last=1, each 1 cycle after the 4th window pixel.
- Mixed signs:
  - Window pixels 0xFC00, 0xFC00, 0xFC00, 0xFC00 (-1.0 each) → 0xF000.
  - Window pixels 0x0400, 0xFC00, 0x0800, 0x0000 → 0x0800.
- Saturation:
  - Four 0x7FFF → 0x7FFF.
  - Four 0x8000 → 0x8000.
  - 0x7000, 0x7000, 0x0000, 0x0000 → 0x7FFF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with a result pending → in_ready=0, out_data stable, no input consumed.
  - Release → stream resumes and the output count is still correct.
- Default 28×28 frame of ramp data, then a second frame back-to-back with in_valid continuously 1:
  - 196 outputs per frame, each equal to a reference-model sum.
  - out_last exactly on outputs #196 and #392.
- Assert rst_n=0 for 1 cycle after 3 pixels of an odd row → out_valid=0, no output emitted. A fresh full 4×2 frame then produces the correct sums.
